// File: rtl/modular_mult_serial.sv
// Serial modular multiplier: R = a*b mod p, interleaved shift-add,
// one bit of a per clock, MSB first.
module modular_mult_serial #(
  parameter int Data_Width = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Data_Width-1:0] a,
  input  logic [Data_Width-1:0] b,
  input  logic [Data_Width-1:0] p,
  input  logic                  valid_in,
  output logic [Data_Width-1:0] R,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int IW = $clog2(Data_Width);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state;
  logic [Data_Width-1:0] a_q;
  logic [Data_Width-1:0] b_q;
  logic [Data_Width-1:0] p_q;
  logic [Data_Width-1:0] acc;
  logic [IW-1:0]         idx;
  logic                  deg;

  logic [Data_Width:0]   dbl;
  logic [Data_Width:0]   pw;
  logic [Data_Width:0]   sum;
  logic [Data_Width-1:0] red1;
  logic [Data_Width-1:0] red2;
  logic [Data_Width-1:0] acc_nxt;

  // Each reduction is one conditional subtract on a W+1-bit value.
  always_comb begin
    dbl  = {acc, 1'b0};
    pw   = {1'b0, p_q};
    red1 = (dbl >= pw) ? Data_Width'(dbl - pw)
                       : Data_Width'(dbl);
    sum  = {1'b0, red1} + {1'b0, b_q};
    red2 = (sum >= pw) ? Data_Width'(sum - pw)
                       : Data_Width'(sum);
    acc_nxt = a_q[Data_Width-1] ? red2 : red1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      acc       <= '0;
      idx       <= '0;
      deg       <= 1'b0;
      R         <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_in) begin
            a_q   <= a;
            b_q   <= b;
            p_q   <= p;
            acc   <= '0;
            idx   <= IW'(Data_Width - 1);
            deg   <= (p < Data_Width'(2));
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          a_q <= a_q << 1;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            // p of 0 or 1 always yields zero
            R         <= deg ? '0 : acc_nxt;
            valid_out <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_mult_serial.sv
// Scoreboard bench for modular_mult_serial: reference is a*b % p
// on wide integers, results checked in a decoupled monitor.
module tb_modular_mult_serial;

  localparam int W = 256;

  typedef struct {
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         valid_in;
  logic [W-1:0] R;
  logic         valid_out;
  logic         busy;

  exp_t sbq[$];
  int   cyc;
  int   checks;
  int   errors;

  modular_mult_serial #(.Data_Width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .p        (p),
    .valid_in (valid_in),
    .R        (R),
    .valid_out(valid_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_mod(
    input logic [W-1:0] x, input logic [W-1:0] y,
    input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] mm;
    if (m < 2) return '0;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    mm   = {{W{1'b0}}, m};
    prod = prod % mm;
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Called at a negedge with busy low; drives one accepted request.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] m);
    exp_t e;
    a = x;
    b = y;
    p = m;
    valid_in = 1'b1;
    e.r   = ref_mod(x, y, m);
    e.cyc = cyc + 1 + W;
    sbq.push_back(e);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2 * W) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  task automatic wait_vout();
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_out && n < 2 * W) begin
      @(negedge clk);
      n++;
    end
    if (!valid_out) begin
      checks++;
      errors++;
      $display("FAIL wait_vout actual=0 required=1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", W'(sbq.size()), '0);
  endtask

  initial begin
    logic [W-1:0] rp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    p        = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && valid_out) begin
            if (sbq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid_out R=%0h", R);
            end else begin
              e = sbq.pop_front();
              chk("result", R, e.r);
              chk("latency", W'(cyc), W'(e.cyc));
            end
          end
        end
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=done");
        $fatal(1, "timeout");
      end
    join_none

    #12;
    chk("rst_R", R, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_vout", W'(valid_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(W'(24'h123456), W'(5), W'(28'hefee431));
    wait_idle();
    chk("basic_R", R, W'(24'h5b05ae));
    send(W'(7), W'(5), W'(13));
    wait_idle();
    chk("wrap_R", R, W'(9));
    send(W'(28'hefee430), W'(28'hefee430), W'(28'hefee431));
    wait_idle();
    send(W'(8'hff), W'(0), W'(1));
    wait_idle();
    send(W'(0), W'(3), W'(13));
    wait_idle();
    send(W'(5), W'(0), W'(0));
    wait_idle();

    // Mid-op strobe with other operands must be ignored
    send(W'(1000), W'(11), W'(97));
    repeat (9) @(negedge clk);
    a = W'(3);
    b = W'(2);
    p = W'(7);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    a = rand_w();
    wait_idle();
    repeat (W + 20) @(negedge clk);

    // Back-to-back accept in the valid_out cycle
    send(W'(6), W'(4), W'(11));
    wait_vout();
    send(W'(2), W'(3), W'(5));
    wait_idle();
    drain();

    // Reset in the middle of a calculation
    send(W'(12345), W'(77), W'(1009));
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_R", R, '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_vout", W'(valid_out), '0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 10) @(negedge clk);
    chk("post_rst_R", R, '0);
    send(W'(7), W'(5), W'(13));
    wait_idle();
    chk("restart_R", R, W'(9));

    for (int i = 0; i < 10; i++) begin
      rp = rand_w() >> $urandom_range(0, 250);
      if (rp < 2) rp = W'(3);
      rb = rand_w() % rp;
      ra = rand_w() >> $urandom_range(0, 8);
      send(ra, rb, rp);
      if ($urandom_range(0, 1) == 1) begin
        wait_vout();
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
